// File: rtl/mux_scan_seq_pkg.sv
// Shared types and sizing helpers for the mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, NEXT} state_t;

  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_ADC_W       = 12;
  localparam int DEF_SETTLE_CYC  = 100;
  localparam int DEF_TIMEOUT_CYC = 1000;

  // Counter width able to hold max(a, b) - 1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_SETTLE_CYC, DEF_TIMEOUT_CYC);

endpackage

// File: rtl/mux_scan_seq_timer.sv
// Loadable down counter shared by the settle delay and the conversion timeout.
module mux_scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Channel scan sequencer: steps the mux address, waits to settle, runs one ADC conversion per channel.
// Define MUX_SCAN_CHMASK_EN to add a per-channel enable mask (ch_mask).
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_CH      = 48,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int ADC_W       = DEF_ADC_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
`ifdef MUX_SCAN_CHMASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              samp_valid,
  output logic [ADDR_W-1:0] samp_ch,
  output logic [ADC_W-1:0]  samp_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = cnt_width(SETTLE_CYC, TIMEOUT_CYC);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              tmr_load, tmr_en, tmr_tc;
  logic [CNT_W-1:0]  tmr_val;
  logic              first_hit, next_hit;
  logic [ADDR_W-1:0] first_ch, next_ch;
  logic              accept, capture, timed_out;

`ifdef MUX_SCAN_CHMASK_EN
  // Downward scan leaves the lowest qualifying index in first_ch/next_ch.
  always_comb begin
    first_hit = 1'b0;
    first_ch  = '0;
    next_hit  = 1'b0;
    next_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_hit = 1'b1;
        first_ch  = ADDR_W'(i);
        if (i > int'(addr)) begin
          next_hit = 1'b1;
          next_ch  = ADDR_W'(i);
        end
      end
    end
  end
`else
  assign first_hit = 1'b1;
  assign first_ch  = '0;
  assign next_hit  = (addr != ADDR_W'(NUM_CH - 1));
  assign next_ch   = addr + ADDR_W'(1);
`endif

  assign accept    = (state == IDLE) && start && !stop;
  assign capture   = (state == WAIT) && adc_done && !stop;
  assign timed_out = (state == WAIT) && !adc_done && tmr_tc && !stop;

  mux_scan_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = CNT_W'(SETTLE_CYC - 1);
    if (stop && (state != IDLE)) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          addr_nxt = '0;
          if (accept) begin
            if (first_hit) begin
              state_nxt = SETTLE;
              addr_nxt  = first_ch;
              tmr_load  = 1'b1;
            end else begin
              state_nxt = NEXT;
            end
          end
        end
        SETTLE: begin
          if (tmr_tc) state_nxt = CONV;
          else        tmr_en    = 1'b1;
        end
        CONV: begin
          state_nxt = WAIT;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(TIMEOUT_CYC - 1);
        end
        WAIT: begin
          if (adc_done || tmr_tc) state_nxt = NEXT;
          else                    tmr_en    = 1'b1;
        end
        NEXT: begin
          if (next_hit) begin
            state_nxt = SETTLE;
            addr_nxt  = next_ch;
            tmr_load  = 1'b1;
          end else if (continuous && first_hit) begin
            state_nxt = SETTLE;
            addr_nxt  = first_ch;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = IDLE;
            addr_nxt  = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          addr_nxt  = '0;
        end
      endcase
    end
  end

  // adc_start is raised as CONV hands over to WAIT, so it lands SETTLE_CYC+1 cycles after an address change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      adc_start   <= 1'b0;
      samp_valid  <= 1'b0;
      samp_ch     <= '0;
      samp_data   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      busy       <= (state_nxt != IDLE);
      adc_start  <= (state == CONV) && !stop;
      samp_valid <= capture;
      if (capture) begin
        samp_ch   <= addr;
        samp_data <= adc_data;
      end
      if (accept)         timeout_err <= 1'b0;
      else if (timed_out) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: table of single sweeps, then wrap/stop, reset and idle corner sequences.
// Define MUX_SCAN_CHMASK_EN to also run the channel-mask vectors.
module tb_mux_scan_seq;

  localparam int ADDR_W      = 6;
  localparam int ADC_W       = 12;
  localparam int NUM_CH      = 3;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int GAP         = SETTLE_CYC + 1;

  typedef struct {
    int         dead_ch;
    int         base;
    logic [2:0] mask;
    logic [2:0] exp_chs;
    logic [2:0] exp_visit;
    int         exp_conv;
    int         exp_to;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] ch;
    logic [ADC_W-1:0]  data;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic stop = 1'b0;
  logic adc_done;
  logic [ADC_W-1:0] adc_data;
  logic [ADDR_W-1:0] addr, samp_ch;
  logic [ADC_W-1:0] samp_data;
  logic adc_start, samp_valid, busy, timeout_err;
`ifdef MUX_SCAN_CHMASK_EN
  logic [NUM_CH-1:0] ch_mask = '1;
`endif

  logic adc_auto = 1'b1;
  int   dead_ch = 99;
  int   data_base = 0;
  logic man_done = 1'b0;
  logic [ADC_W-1:0] man_data = '0;
  logic mdl_done = 1'b0;
  logic [ADC_W-1:0] mdl_data = '0;
  int   pend_cnt = 0;
  int   pend_ch = 0;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int change_cyc = 0;
  int start_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_to = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  samp_t sq[$];
  int    gap_q[$];
  int    to_q[$];
  int    addr_q[$];
  vec_t  vecs[$];

  assign adc_done = adc_auto ? mdl_done : man_done;
  assign adc_data = adc_auto ? mdl_data : man_data;

  mux_scan_seq #(
    .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .SETTLE_CYC(SETTLE_CYC),
    .ADC_W(ADC_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .stop        (stop),
`ifdef MUX_SCAN_CHMASK_EN
    .ch_mask     (ch_mask),
`endif
    .addr        (addr),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .samp_valid  (samp_valid),
    .samp_ch     (samp_ch),
    .samp_data   (samp_data),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ADC model: answers 3 cycles after adc_start with base+channel, except on the dead channel.
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (!adc_auto) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mdl_done = 1'b1;
          mdl_data = ADC_W'(data_base + pend_ch);
        end
      end
      if (adc_start && (int'(addr) != dead_ch)) begin
        pend_cnt = 3;
        pend_ch  = int'(addr);
      end
    end
  end

  // Event recorder: samples, settle gaps, timeout latency and addresses visited while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((busy && !prev_busy) || (addr != prev_addr)) begin
        change_cyc = cyc;
        if (busy) addr_q.push_back(int'(addr));
      end
      if (adc_start) begin
        gap_q.push_back(cyc - change_cyc);
        start_cyc = cyc;
      end
      if (timeout_err && !prev_to) to_q.push_back(cyc - start_cyc);
      if (samp_valid) sq.push_back(samp_t'{samp_ch, samp_data});
    end
    prev_busy = busy;
    prev_addr = addr;
    prev_to   = timeout_err;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitBusyLow(input int max_cyc);
    for (int n = 0; n < max_cyc && busy; n++) @(negedge clk);
    checkOutput("sweep_done_busy", busy, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"}, addr, 0);
    checkOutput({tag, "_adc_start"}, adc_start, 0);
    checkOutput({tag, "_samp_valid"}, samp_valid, 0);
    checkOutput({tag, "_samp_ch"}, samp_ch, 0);
    checkOutput({tag, "_samp_data"}, samp_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, g0, t0, a0, idx;
    logic [63:0] seen;
    int found;
    int idle_seen;

    // dead_ch, base, mask, exp sampled chs, exp visited addrs, exp adc_starts, exp timeouts
    vecs.push_back(vec_t'{99, 'h100, 3'b111, 3'b111, 3'b111, 3, 0});
    vecs.push_back(vec_t'{1,  'h200, 3'b111, 3'b101, 3'b111, 3, 1});
    vecs.push_back(vec_t'{99, 'h555, 3'b111, 3'b111, 3'b111, 3, 0});
    vecs.push_back(vec_t'{2,  'hFF0, 3'b111, 3'b011, 3'b111, 3, 1});
    vecs.push_back(vec_t'{0,  'h010, 3'b111, 3'b110, 3'b111, 3, 1});
`ifdef MUX_SCAN_CHMASK_EN
    vecs.push_back(vec_t'{99, 'h100, 3'b101, 3'b101, 3'b101, 2, 0});
    vecs.push_back(vec_t'{2,  'h300, 3'b110, 3'b010, 3'b110, 2, 1});
    vecs.push_back(vec_t'{99, 'h0A0, 3'b100, 3'b100, 3'b100, 1, 0});
`endif

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      adc_auto  = 1'b1;
      dead_ch   = vecs[v].dead_ch;
      data_base = vecs[v].base;
`ifdef MUX_SCAN_CHMASK_EN
      ch_mask   = vecs[v].mask;
`endif
      s0 = sq.size(); g0 = gap_q.size(); t0 = to_q.size(); a0 = addr_q.size();
      applyStimulus();
      checkOutput("start_busy", busy, 1);
      checkOutput("start_clears_timeout", timeout_err, 0);
      waitBusyLow(300);
      @(negedge clk);
      checkOutput("sample_count", sq.size() - s0, $countones(vecs[v].exp_chs));
      idx = s0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (vecs[v].exp_chs[ch] && idx < sq.size()) begin
          checkOutput("samp_ch", sq[idx].ch, ch);
          checkOutput("samp_data", sq[idx].data, vecs[v].base + ch);
          idx++;
        end
      end
      checkOutput("adc_start_count", gap_q.size() - g0, vecs[v].exp_conv);
      checkOutput("timeout_count", to_q.size() - t0, vecs[v].exp_to);
      checkOutput("timeout_err_end", timeout_err, vecs[v].exp_to);
      seen = '0;
      for (int i = a0; i < addr_q.size(); i++) seen[addr_q[i]] = 1'b1;
      checkOutput("addr_visited", seen, vecs[v].exp_visit);
      checkOutput("end_addr", addr, 0);
    end
`ifdef MUX_SCAN_CHMASK_EN
    ch_mask = '1;
`endif

    // Continuous scan: 2 -> 0 wrap without an idle cycle, then stop+adc_done together in WAIT on ch0.
    adc_auto = 1'b1; dead_ch = 99; data_base = 'h100; continuous = 1'b1;
    applyStimulus();
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      if (addr == 2) found = 1;
      else @(negedge clk);
    end
    checkOutput("wrap_reach_ch2", found, 1);
    idle_seen = 0;
    for (int n = 0; n < 100 && addr == 2; n++) begin
      if (!busy) idle_seen++;
      @(negedge clk);
    end
    checkOutput("wrap_addr", addr, 0);
    checkOutput("wrap_busy", busy, 1);
    checkOutput("wrap_no_idle", idle_seen, 0);
    for (int n = 0; n < 50 && !adc_start; n++) @(negedge clk);
    checkOutput("wrap_conv_ch0", {adc_start, addr}, {1'b1, 6'd0});
    adc_auto = 1'b0;
    @(negedge clk);
    s0 = sq.size();
    stop = 1'b1; man_done = 1'b1; man_data = 'hABC;
    @(negedge clk);
    stop = 1'b0; man_done = 1'b0;
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_addr", addr, 0);
    checkOutput("stop_samp_valid", samp_valid, 0);
    @(negedge clk);
    checkOutput("stop_samp_valid_late", samp_valid, 0);
    checkOutput("stop_no_sample", sq.size() - s0, 0);
    continuous = 1'b0;

    // Reset asserted in the middle of WAIT.
    applyStimulus();
    for (int n = 0; n < 50 && !adc_start; n++) @(negedge clk);
    checkOutput("rst_seq_conv", adc_start, 1);
    repeat (2) @(negedge clk);
    checkOutput("rst_seq_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_done = 1'b1; man_data = 'h777;
    @(negedge clk);
    man_done = 1'b0;
    checkOutput("post_reset_no_sample", samp_valid, 0);
    @(negedge clk);
    checkOutput("post_reset_no_sample2", samp_valid, 0);
    checkOutput("post_reset_busy", busy, 0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checkOutput("start_stop_idle", busy, 0);
    @(negedge clk);
    checkOutput("start_stop_idle2", busy, 0);

`ifdef MUX_SCAN_CHMASK_EN
    // Empty mask: accepted, but back to IDLE within 2 cycles with no conversion.
    adc_auto = 1'b1;
    ch_mask = '0;
    g0 = gap_q.size();
    applyStimulus();
    @(negedge clk);
    checkOutput("mask0_idle", busy, 0);
    repeat (4) @(negedge clk);
    checkOutput("mask0_no_conv", gap_q.size() - g0, 0);
    ch_mask = '1;
`endif

    foreach (gap_q[i]) checkOutput("settle_gap", gap_q[i], GAP);
    foreach (to_q[i]) checkOutput("timeout_wait", to_q[i], TIMEOUT_CYC);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
